// File: rtl/scumv_uart_protocol_mux.sv
// Prefix-routed byte multiplexer: a 4-byte host tag selects a channel, a fixed-length request
// is forwarded to it and its fixed-length response is returned to the host UART.
module scumv_uart_protocol_mux #(
  parameter int                   NUM_CH         = 2,
  parameter logic [NUM_CH*32-1:0] PREFIX_TABLE   = {"stl+", "asc+"},
  parameter logic [NUM_CH*8-1:0]  REQ_LEN_TABLE  = {8'd16, 8'd22},
  parameter logic [NUM_CH*8-1:0]  RSP_LEN_TABLE  = {8'd16, 8'd1},
  parameter int                   TIMEOUT_CYCLES = 1_000_000,
  localparam int                  CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           ch_req_data,
  output logic [NUM_CH-1:0]    ch_req_valid,
  input  logic [NUM_CH-1:0]    ch_req_ready,
  input  logic [NUM_CH*8-1:0]  ch_rsp_data,
  input  logic [NUM_CH-1:0]    ch_rsp_valid,
  output logic [NUM_CH-1:0]    ch_rsp_ready,
  output logic [CH_W-1:0]      active_ch,
  output logic                 busy,
  output logic                 err_pulse,
  output logic [7:0]           err_count,
  output logic [1:0]           debug_state
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PREFIX = 2'd1, FWD = 2'd2, RSP = 2'd3} state_e;

  state_e              state_r, state_next_s;
  logic [7:0]          pfx0_r, pfx1_r, pfx2_r;
  logic [7:0]          pcnt_r, bcnt_r;
  logic [CH_W-1:0]     sel_r;
  logic [31:0]         tcnt_r;
  logic [7:0]          err_cnt_r;
  logic                err_pulse_r;

  logic [NUM_CH-1:0]   sel_oh_s;
  logic [7:0]          req_len_s, rsp_len_s, rsp_data_s;
  logic                rsp_valid_s, req_ready_s;
  logic                match_s;
  logic [CH_W-1:0]     match_idx_s;
  logic                rx_ready_s, tx_valid_s;
  logic [7:0]          tx_data_s;
  logic [NUM_CH-1:0]   ch_req_valid_s, ch_rsp_ready_s;
  logic                rx_acc_s, tx_acc_s, last_req_s, last_rsp_s;
  logic                to_s, bad_tag_s, err_s;

  // Table lookup for the selected channel and lowest-index tag match against the incoming prefix
  always_comb begin
    sel_oh_s    = '0;
    req_len_s   = 8'd0;
    rsp_len_s   = 8'd0;
    rsp_data_s  = 8'd0;
    rsp_valid_s = 1'b0;
    req_ready_s = 1'b0;
    match_s     = 1'b0;
    match_idx_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_oh_s[k] = (sel_r == CH_W'(k));
      req_len_s   = req_len_s  | ({8{sel_oh_s[k]}} & REQ_LEN_TABLE[k*8 +: 8]);
      rsp_len_s   = rsp_len_s  | ({8{sel_oh_s[k]}} & RSP_LEN_TABLE[k*8 +: 8]);
      rsp_data_s  = rsp_data_s | ({8{sel_oh_s[k]}} & ch_rsp_data[k*8 +: 8]);
      rsp_valid_s = rsp_valid_s | (sel_oh_s[k] & ch_rsp_valid[k]);
      req_ready_s = req_ready_s | (sel_oh_s[k] & ch_req_ready[k]);
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      match_idx_s = ({pfx0_r, pfx1_r, pfx2_r, rx_data} == PREFIX_TABLE[k*32 +: 32]) ? CH_W'(k) : match_idx_s;
      match_s     = match_s | ({pfx0_r, pfx1_r, pfx2_r, rx_data} == PREFIX_TABLE[k*32 +: 32]);
    end
  end

  // Combinational byte-path steering, forced quiet while reset is held
  always_comb begin
    rx_ready_s     = 1'b0;
    tx_valid_s     = 1'b0;
    tx_data_s      = 8'd0;
    ch_req_valid_s = '0;
    ch_rsp_ready_s = '0;
    if (reset) begin
      rx_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE, PREFIX: rx_ready_s = 1'b1;
        FWD: begin
          rx_ready_s     = req_ready_s;
          ch_req_valid_s = sel_oh_s & {NUM_CH{rx_valid}};
        end
        RSP: begin
          tx_valid_s     = rsp_valid_s;
          tx_data_s      = rsp_data_s;
          ch_rsp_ready_s = sel_oh_s & {NUM_CH{tx_ready}};
        end
        default: rx_ready_s = 1'b0;
      endcase
    end
  end

  assign rx_acc_s   = rx_valid & rx_ready_s;
  assign tx_acc_s   = tx_valid_s & tx_ready;
  assign last_req_s = (bcnt_r == (req_len_s - 8'd1));
  assign last_rsp_s = (bcnt_r == (rsp_len_s - 8'd1));
  // An accept in the expiry cycle keeps the frame alive
  assign to_s       = (TIMEOUT_CYCLES != 0) && (state_r != IDLE) && (tcnt_r == TO_LAST) && !rx_acc_s && !tx_acc_s;
  assign bad_tag_s  = (state_r == PREFIX) && rx_acc_s && (pcnt_r == 8'd3) && !match_s;
  assign err_s      = bad_tag_s | to_s;

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = rx_acc_s ? PREFIX : IDLE;
      PREFIX: begin
        if (rx_acc_s && (pcnt_r == 8'd3)) state_next_s = match_s ? FWD : IDLE;
        else if (to_s)                     state_next_s = IDLE;
        else                               state_next_s = PREFIX;
      end
      FWD: begin
        if (rx_acc_s && last_req_s) state_next_s = (rsp_len_s != 8'd0) ? RSP : IDLE;
        else if (to_s)              state_next_s = IDLE;
        else                        state_next_s = FWD;
      end
      RSP: begin
        if ((tx_acc_s && last_rsp_s) || to_s) state_next_s = IDLE;
        else                                  state_next_s = RSP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Prefix buffer, byte counters, channel select, idle timer and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pfx0_r      <= 8'd0;
      pfx1_r      <= 8'd0;
      pfx2_r      <= 8'd0;
      pcnt_r      <= 8'd0;
      bcnt_r      <= 8'd0;
      sel_r       <= '0;
      tcnt_r      <= 32'd0;
      err_cnt_r   <= 8'd0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= err_s;
      if (err_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
      if ((state_next_s != state_r) || rx_acc_s || tx_acc_s || (state_r == IDLE)) tcnt_r <= 32'd0;
      else                                                                         tcnt_r <= tcnt_r + 32'd1;
      case (state_r)
        IDLE: if (rx_acc_s) begin
          pfx0_r <= rx_data;
          pcnt_r <= 8'd1;
        end
        PREFIX: if (rx_acc_s) begin
          if (pcnt_r == 8'd1) pfx1_r <= rx_data;
          if (pcnt_r == 8'd2) pfx2_r <= rx_data;
          if (pcnt_r == 8'd3) begin
            pcnt_r <= 8'd0;
            bcnt_r <= 8'd0;
            if (match_s) sel_r <= match_idx_s;
          end else begin
            pcnt_r <= pcnt_r + 8'd1;
          end
        end
        FWD: if (rx_acc_s) bcnt_r <= last_req_s ? 8'd0 : bcnt_r + 8'd1;
        RSP: if (tx_acc_s) bcnt_r <= last_rsp_s ? 8'd0 : bcnt_r + 8'd1;
        default: bcnt_r <= 8'd0;
      endcase
    end
  end

  assign rx_ready     = rx_ready_s;
  assign tx_valid     = tx_valid_s;
  assign tx_data      = tx_data_s;
  assign ch_req_data  = rx_data;
  assign ch_req_valid = ch_req_valid_s;
  assign ch_rsp_ready = ch_rsp_ready_s;
  assign active_ch    = sel_r;
  assign busy         = !reset && ((state_r == FWD) || (state_r == RSP));
  assign err_pulse    = err_pulse_r & !reset;
  assign err_count    = reset ? 8'd0 : err_cnt_r;
  assign debug_state  = state_r;

endmodule

// File: tb/tb_scumv_uart_protocol_mux.sv
// Bench for scumv_uart_protocol_mux: instance 0 has a 100-cycle timeout, instance 1 has no
// channel-0 response; random frames are checked against a tag/length reference model.
module tb_scumv_uart_protocol_mux;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][7:0]  rx_data;
  logic [1:0]       rx_valid, rx_ready;
  logic [1:0][7:0]  tx_data;
  logic [1:0]       tx_valid, tx_ready;
  logic [1:0][7:0]  ch_req_data;
  logic [1:0][1:0]  ch_req_valid, ch_req_ready;
  logic [1:0][15:0] ch_rsp_data;
  logic [1:0][1:0]  ch_rsp_valid, ch_rsp_ready;
  logic [1:0]       active_ch, busy, err_pulse;
  logic [1:0][7:0]  err_count;
  logic [1:0][1:0]  debug_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  scumv_uart_protocol_mux #(.TIMEOUT_CYCLES(100)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .ch_req_data(ch_req_data[0]), .ch_req_valid(ch_req_valid[0]), .ch_req_ready(ch_req_ready[0]),
    .ch_rsp_data(ch_rsp_data[0]), .ch_rsp_valid(ch_rsp_valid[0]), .ch_rsp_ready(ch_rsp_ready[0]),
    .active_ch(active_ch[0]), .busy(busy[0]), .err_pulse(err_pulse[0]), .err_count(err_count[0]),
    .debug_state(debug_state[0]));

  scumv_uart_protocol_mux #(.RSP_LEN_TABLE({8'd16, 8'd0}), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .ch_req_data(ch_req_data[1]), .ch_req_valid(ch_req_valid[1]), .ch_req_ready(ch_req_ready[1]),
    .ch_rsp_data(ch_rsp_data[1]), .ch_rsp_valid(ch_rsp_valid[1]), .ch_rsp_ready(ch_rsp_ready[1]),
    .active_ch(active_ch[1]), .busy(busy[1]), .err_pulse(err_pulse[1]), .err_count(err_count[1]),
    .debug_state(debug_state[1]));

  // Reference model: tag table, request lengths, response lengths per instance/channel
  logic [31:0] tag_m [2];
  int          req_m [2]    = '{22, 16};
  int          rsp_m [2][2] = '{'{1, 16}, '{0, 16}};

  int tests = 0, fails = 0;
  int exp_err [2]  = '{0, 0};
  int err_seen [2] = '{0, 0};
  int err_cyc [2]  = '{0, 0};
  int txv_seen [2] = '{0, 0};
  int req_q [$];
  int tx_q [$];
  bit rnd = 1'b0;
  int acc_cyc = 0;

  function automatic int model_ch(input logic [31:0] t);
    for (int k = 0; k < 2; k++) if (t == tag_m[k]) return k;
    return -1;
  endfunction

  // Passive monitor: logs accepted beats and error pulses of both instances
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0) begin
      for (int u = 0; u < 2; u++) begin
        for (int k = 0; k < 2; k++)
          if (ch_req_valid[u][k] && ch_req_ready[u][k]) req_q.push_back(u*65536 + k*256 + int'(ch_req_data[u]));
        if (tx_valid[u] && tx_ready[u]) tx_q.push_back(u*256 + int'(tx_data[u]));
        if (tx_valid[u]) txv_seen[u]++;
        if (err_pulse[u]) begin err_seen[u]++; err_cyc[u] = cyc; end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input int u, input logic [7:0] b);
    int n = 0;
    rx_data[u] = b;
    rx_valid[u] = 1'b1;
    forever begin
      if (rnd) begin ch_req_ready[u] = 2'($urandom); tx_ready[u] = 1'($urandom); end
      @(negedge clk);
      if (rx_ready[u] || n > 200) break;
      n++;
      @(posedge clk); #1;
    end
    if (n > 200) begin
      tests++; fails++;
      $display("FAIL send_byte u%0d: byte 0x%02h got no rx_ready in 200 cycles, expected accept", u, b);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    rx_valid[u] = 1'b0;
  endtask

  task automatic respond(input int u, input int ch, input logic [7:0] b);
    int n = 0;
    ch_rsp_data[u][ch*8 +: 8] = b;
    ch_rsp_valid[u][ch] = 1'b1;
    forever begin
      tx_ready[u] = rnd ? 1'($urandom) : 1'b1;
      @(negedge clk);
      if (ch_rsp_ready[u][ch] || n > 200) break;
      n++;
      @(posedge clk); #1;
    end
    if (n > 200) begin
      tests++; fails++;
      $display("FAIL respond u%0d: byte 0x%02h got no ch_rsp_ready in 200 cycles, expected accept", u, b);
    end
    @(posedge clk); #1;
    ch_rsp_valid[u][ch] = 1'b0;
    tx_ready[u] = 1'b1;
  endtask

  task automatic run_frame(input int u, input logic [31:0] tag, input int req_base, input int rsp_base, input string name);
    int ch, e0, got;
    int exp_req [$];
    int exp_tx [$];
    logic [7:0] b;
    ch = model_ch(tag);
    req_q.delete(); tx_q.delete();
    e0 = err_seen[u];
    for (int i = 0; i < 4; i++) begin send_byte(u, tag[31-8*i -: 8]); tick($urandom_range(0, 2)); end
    if (ch < 0) begin
      if (exp_err[u] < 255) exp_err[u]++;
    end else begin
      tests++;
      if (busy[u] !== 1'b1 || debug_state[u] !== 2'd2 || active_ch[u] !== 1'(ch))
        begin fails++; $display("FAIL %s sel: busy=%0d state=%0d ch=%0d, expected 1/2/%0d", name, busy[u], debug_state[u], active_ch[u], ch); end
      for (int i = 0; i < req_m[ch]; i++) begin
        b = (req_base < 0) ? 8'($urandom) : 8'(req_base + i);
        exp_req.push_back(u*65536 + ch*256 + int'(b));
        send_byte(u, b);
        if (i == req_m[ch] - 1) begin
          tests++;
          if (debug_state[u] !== ((rsp_m[u][ch] != 0) ? 2'd3 : 2'd0))
            begin fails++; $display("FAIL %s after_last_req: state=%0d, expected %0d", name, debug_state[u], (rsp_m[u][ch] != 0) ? 3 : 0); end
        end
        tick($urandom_range(0, 2));
      end
      for (int i = 0; i < rsp_m[u][ch]; i++) begin
        b = (rsp_base < 0) ? 8'($urandom) : 8'(rsp_base + i);
        exp_tx.push_back(u*256 + int'(b));
        respond(u, ch, b);
      end
    end
    tick(3);
    tests++;
    if (req_q.size() != exp_req.size()) begin fails++; $display("FAIL %s req_count: got %0d, expected %0d", name, req_q.size(), exp_req.size()); end
    for (int i = 0; i < exp_req.size(); i++) begin
      got = (i < req_q.size()) ? req_q[i] : -1;
      tests++;
      if (got != exp_req[i]) begin fails++; $display("FAIL %s req[%0d]: got 0x%0h, expected 0x%0h", name, i, got, exp_req[i]); end
    end
    tests++;
    if (tx_q.size() != exp_tx.size()) begin fails++; $display("FAIL %s tx_count: got %0d, expected %0d", name, tx_q.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : -1;
      tests++;
      if (got != exp_tx[i]) begin fails++; $display("FAIL %s tx[%0d]: got 0x%0h, expected 0x%0h", name, i, got, exp_tx[i]); end
    end
    tests++;
    if (err_count[u] !== 8'(exp_err[u])) begin fails++; $display("FAIL %s err_count: got %0d, expected %0d", name, err_count[u], exp_err[u]); end
    tests++;
    if (err_seen[u] - e0 != ((ch < 0) ? 1 : 0)) begin fails++; $display("FAIL %s err_pulses: got %0d, expected %0d", name, err_seen[u] - e0, (ch < 0) ? 1 : 0); end
    tests++;
    if (debug_state[u] !== 2'd0) begin fails++; $display("FAIL %s end_state: got %0d, expected 0", name, debug_state[u]); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 2'b11; rx_data = 16'($urandom);
    tx_ready = 2'b11; ch_req_ready = 4'hF;
    ch_rsp_valid = 4'hF; ch_rsp_data = 32'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      tests++;
      if ({rx_ready[u], tx_valid[u], ch_req_valid[u], ch_rsp_ready[u], busy[u], err_pulse[u]} !== 7'd0)
        begin fails++; $display("FAIL reset_outputs u%0d: got %b, expected 0", u, {rx_ready[u], tx_valid[u], ch_req_valid[u], ch_rsp_ready[u], busy[u], err_pulse[u]}); end
      tests++;
      if (err_count[u] !== 8'd0) begin fails++; $display("FAIL reset_err_count u%0d: got %0d, expected 0", u, err_count[u]); end
    end
    rx_valid = 2'b00; ch_rsp_valid = 4'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      tests++;
      if (debug_state[u] !== 2'd0 || rx_ready[u] !== 1'b1 || busy[u] !== 1'b0)
        begin fails++; $display("FAIL reset_idle u%0d: state=%0d rx_ready=%0d busy=%0d, expected 0/1/0", u, debug_state[u], rx_ready[u], busy[u]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_asc();
    run_frame(0, "asc+", 0, 8'hA5, "asc");
  endtask

  task automatic test_stl_backpressure();
    rnd = 1'b1;
    run_frame(0, "stl+", -1, 8'h80, "stl_bp");
    rnd = 1'b0; ch_req_ready = 4'hF; tx_ready = 2'b11;
  endtask

  task automatic test_bad_tag();
    run_frame(0, "abc+", -1, -1, "bad_tag");
    run_frame(0, "asc+", -1, -1, "recover");
  endtask

  task automatic test_timeout();
    int a0, e0, n;
    logic [31:0] t;
    t = "stl+";
    req_q.delete();
    e0 = err_seen[0];
    for (int i = 0; i < 4; i++) send_byte(0, t[31-8*i -: 8]);
    for (int i = 0; i < 5; i++) send_byte(0, 8'($urandom));
    a0 = acc_cyc;
    n = 0;
    while (err_seen[0] == e0 && n < 300) begin @(posedge clk); #1; n++; end
    tick(2);
    if (exp_err[0] < 255) exp_err[0]++;
    tests++;
    if (err_seen[0] - e0 != 1) begin fails++; $display("FAIL timeout_pulses: got %0d, expected 1", err_seen[0] - e0); end
    tests++;
    if (err_cyc[0] - a0 != 100) begin fails++; $display("FAIL timeout_latency: got %0d cycles, expected 100", err_cyc[0] - a0); end
    tests++;
    if (err_count[0] !== 8'(exp_err[0])) begin fails++; $display("FAIL timeout_err_count: got %0d, expected %0d", err_count[0], exp_err[0]); end
    tests++;
    if (debug_state[0] !== 2'd0 || req_q.size() != 5)
      begin fails++; $display("FAIL timeout_abandon: state=%0d beats=%0d, expected 0/5", debug_state[0], req_q.size()); end
    run_frame(0, "stl+", -1, -1, "after_timeout");
  endtask

  task automatic test_back_to_back();
    logic [31:0] t;
    rnd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       t = "asc+";
        1:       t = "stl+";
        default: t = $urandom;
      endcase
      run_frame(0, t, -1, -1, "b2b");
    end
    rnd = 1'b0; ch_req_ready = 4'hF; tx_ready = 2'b11;
  endtask

  task automatic test_no_rsp();
    int t0;
    logic [31:0] t;
    t0 = txv_seen[1];
    run_frame(1, "asc+", -1, -1, "no_rsp");
    tests++;
    if (txv_seen[1] != t0) begin fails++; $display("FAIL no_rsp_tx_valid: got %0d cycles, expected 0", txv_seen[1] - t0); end
    run_frame(1, "qqq+", -1, -1, "no_rsp_bad");
    t = "asc+";
    for (int i = 0; i < 4; i++) send_byte(1, t[31-8*i -: 8]);
    for (int i = 0; i < 5; i++) send_byte(1, 8'($urandom));
    tests++;
    if (debug_state[1] !== 2'd2) begin fails++; $display("FAIL mid_fwd_state: got %0d, expected 2", debug_state[1]); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_err[0] = 0; exp_err[1] = 0;
    tests++;
    if (debug_state[1] !== 2'd0 || err_count[1] !== 8'd0 || err_count[0] !== 8'd0)
      begin fails++; $display("FAIL mid_fwd_reset: state=%0d err1=%0d err0=%0d, expected 0/0/0", debug_state[1], err_count[1], err_count[0]); end
    run_frame(1, "stl+", -1, -1, "post_reset");
  endtask

  task automatic test_saturate();
    int e0;
    logic [31:0] t;
    req_q.delete();
    e0 = err_seen[0];
    for (int i = 0; i < 260; i++) begin
      do t = $urandom; while (model_ch(t) >= 0);
      for (int j = 0; j < 4; j++) send_byte(0, t[31-8*j -: 8]);
      if (exp_err[0] < 255) exp_err[0]++;
    end
    tick(3);
    tests++;
    if (err_count[0] !== 8'(exp_err[0]) || exp_err[0] != 255)
      begin fails++; $display("FAIL saturate_count: got %0d, expected %0d", err_count[0], exp_err[0]); end
    tests++;
    if (err_seen[0] - e0 != 260) begin fails++; $display("FAIL saturate_pulses: got %0d, expected 260", err_seen[0] - e0); end
    tests++;
    if (req_q.size() != 0) begin fails++; $display("FAIL saturate_no_fwd: got %0d beats, expected 0", req_q.size()); end
  endtask

  initial begin
    tag_m[0] = "asc+";
    tag_m[1] = "stl+";
    test_reset();
    test_asc();
    test_stl_backpressure();
    test_bad_tag();
    test_timeout();
    test_back_to_back();
    test_no_rsp();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
